// File: rtl/sprite_line_scanner_if.sv
// OAM read port and VRAM byte-fetch handshake between the line scanner and its neighbours.
// fetch_req/fetch_ack: req holds index/plane stable until ack; a byte transfers on req && ack.
interface sprite_line_scanner_if;
    logic [5:0] scan_index;
    logic [7:0] scan_y;
    logic       fetch_req;
    logic [5:0] fetch_index;
    logic       fetch_plane;
    logic       fetch_ack;
    logic [1:0] fetch_ds;

    modport master (
        output scan_index,
        input  scan_y,
        output fetch_req,
        output fetch_index,
        output fetch_plane,
        output fetch_ds,
        input  fetch_ack
    );

    modport slave (
        input  scan_index,
        output scan_y,
        input  fetch_req,
        input  fetch_index,
        input  fetch_plane,
        input  fetch_ds,
        output fetch_ack
    );
endinterface

// File: rtl/sprite_line_scanner.sv
// Per-line OAM scan selecting the first visible sprites, then two VRAM byte fetches per
// selected sprite (plane 0 then plane 1) with per-sprite data strobes.
module sprite_line_scanner #(
    parameter int NUM_OAM     = 40,
    parameter int MAX_SPRITES = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           v_cnt,
    input  logic                 size16,
    sprite_line_scanner_if.master bus,
    output logic [NUM_OAM-1:0]   sprite_enable,
    output logic [3:0]           sel_count,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [5:0] LAST_CNT = 6'(NUM_OAM);
    localparam logic [3:0] MAX_SEL  = 4'(MAX_SPRITES);

    logic [1:0] state;
    logic [7:0] v_lat;
    logic       size16_lat;
    logic [5:0] scan_cnt;
    logic [5:0] sel_list [MAX_SPRITES];
    logic [3:0] fetch_ptr;
    logic       plane;

    logic [7:0] v_plus;
    logic [7:0] y_end;
    logic       visible;
    logic       take;
    logic [5:0] eval_index;
    logic       last_byte;

    // scan_y answers the index issued one cycle earlier, so entry scan_cnt-1 is judged now.
    always_comb begin
        v_plus     = v_lat + 8'd16;
        y_end      = bus.scan_y + (size16_lat ? 8'd16 : 8'd8);
        visible    = (v_plus >= bus.scan_y) && (v_plus < y_end);
        eval_index = scan_cnt - 6'd1;
        take       = (state == S_SCAN) && (scan_cnt != 6'd0) && visible && (sel_count < MAX_SEL);
        last_byte  = plane && (fetch_ptr == sel_count - 4'd1);
    end

    always_comb begin
        busy            = (state == S_SCAN) || (state == S_FETCH);
        done            = (state == S_DONE);
        dbg_state       = state;
        bus.scan_index  = ((state == S_SCAN) && (scan_cnt < LAST_CNT)) ? scan_cnt : 6'd0;
        bus.fetch_req   = (state == S_FETCH);
        bus.fetch_index = bus.fetch_req ? sel_list[fetch_ptr] : 6'd0;
        bus.fetch_plane = bus.fetch_req ? plane : 1'b0;
        bus.fetch_ds    = 2'b00;
        if (bus.fetch_req && bus.fetch_ack) begin
            bus.fetch_ds = plane ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            v_lat         <= 8'd0;
            size16_lat    <= 1'b0;
            scan_cnt      <= 6'd0;
            sprite_enable <= '0;
            sel_count     <= 4'd0;
            fetch_ptr     <= 4'd0;
            plane         <= 1'b0;
            for (int i = 0; i < MAX_SPRITES; i++) begin
                sel_list[i] <= 6'd0;
            end
        end else if (start) begin
            // A start in any state restarts the line; an aborted line never reaches DONE.
            state         <= S_SCAN;
            v_lat         <= v_cnt;
            size16_lat    <= size16;
            scan_cnt      <= 6'd0;
            sprite_enable <= '0;
            sel_count     <= 4'd0;
            fetch_ptr     <= 4'd0;
            plane         <= 1'b0;
        end else begin
            case (state)
                S_SCAN: begin
                    if (take) begin
                        sel_list[sel_count]       <= eval_index;
                        sprite_enable[eval_index] <= 1'b1;
                        sel_count                 <= sel_count + 4'd1;
                    end
                    if (scan_cnt == LAST_CNT) begin
                        state <= (take || (sel_count != 4'd0)) ? S_FETCH : S_DONE;
                    end else begin
                        scan_cnt <= scan_cnt + 6'd1;
                    end
                end
                S_FETCH: begin
                    if (bus.fetch_ack) begin
                        if (!plane) begin
                            plane <= 1'b1;
                        end else begin
                            plane <= 1'b0;
                            if (last_byte) begin
                                state <= S_DONE;
                            end else begin
                                fetch_ptr <= fetch_ptr + 4'd1;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner: visibility table plus fetch, ack-delay, abort and reset sequences.
module tb_sprite_line_scanner;
    typedef struct {
        logic [7:0] v;
        logic       sz;
        logic [7:0] y;
        logic       vis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  v_cnt = 8'd0;
    logic        size16 = 1'b0;
    logic [39:0] sprite_enable;
    logic [3:0]  sel_count;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    sprite_line_scanner_if bus();

    sprite_line_scanner dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .v_cnt         (v_cnt),
        .size16        (size16),
        .bus           (bus),
        .sprite_enable (sprite_enable),
        .sel_count     (sel_count),
        .busy          (busy),
        .done          (done),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int ack_mode = 0;
    int wait_cnt = 0;
    int ds_err = 0;
    int stab_err = 0;
    logic [7:0] oam_y [40];
    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];
    int done_q [$];
    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    logic [6:0] prev_sel = 7'd0;
    logic [1:0] ds_exp;
    vec_t vecs [11];

    always @(posedge clk) cyc <= cyc + 1;

    // OAM RAM model: y of the addressed entry appears one cycle after the address.
    always @(posedge clk) bus.scan_y <= oam_y[bus.scan_index];

    // VRAM model: ack tied high, or ack after three waiting cycles per byte.
    always @(negedge clk) begin
        if (ack_mode == 0) begin
            bus.fetch_ack = 1'b1;
            wait_cnt = 0;
        end else if (!bus.fetch_req) begin
            bus.fetch_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt == 3) begin
            bus.fetch_ack = 1'b1;
            wait_cnt = 0;
        end else begin
            bus.fetch_ack = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (bus.fetch_req && bus.fetch_ack)
            got_q.push_back({bus.fetch_index, bus.fetch_plane, bus.fetch_ds});
        ds_exp = (bus.fetch_req && bus.fetch_ack) ? (bus.fetch_plane ? 2'b10 : 2'b01) : 2'b00;
        if (bus.fetch_ds != ds_exp) ds_err++;
        if (prev_req && !prev_ack && bus.fetch_req && ({bus.fetch_index, bus.fetch_plane} != prev_sel))
            stab_err++;
        prev_req = bus.fetch_req;
        prev_ack = bus.fetch_ack;
        prev_sel = {bus.fetch_index, bus.fetch_plane};
        if (done) done_q.push_back(cyc - t0);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_sprite(input logic [5:0] e);
        exp_q.push_back({e, 1'b0, 2'b01});
        exp_q.push_back({e, 1'b1, 2'b10});
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic start_line(input logic [7:0] v, input logic sz);
        @(negedge clk);
        t0 = cyc;
        got_q.delete();
        done_q.delete();
        v_cnt = v;
        size16 = sz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (done_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
        end
    endtask

    task automatic set_oam(input logic [7:0] fill);
        for (int k = 0; k < 40; k++) oam_y[k] = fill;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.scan_y = 8'd0;
        bus.fetch_ack = 1'b0;
        set_oam(8'd0);
        vecs[0]  = '{8'd50,  1'b0, 8'd0,   1'b0};
        vecs[1]  = '{8'd50,  1'b0, 8'd66,  1'b1};
        vecs[2]  = '{8'd50,  1'b0, 8'd59,  1'b1};
        vecs[3]  = '{8'd50,  1'b0, 8'd58,  1'b0};
        vecs[4]  = '{8'd50,  1'b0, 8'd67,  1'b0};
        vecs[5]  = '{8'd50,  1'b1, 8'd56,  1'b1};
        vecs[6]  = '{8'd50,  1'b0, 8'd56,  1'b0};
        vecs[7]  = '{8'd50,  1'b1, 8'd51,  1'b1};
        vecs[8]  = '{8'd50,  1'b1, 8'd50,  1'b0};
        vecs[9]  = '{8'd250, 1'b0, 8'd4,   1'b1};
        vecs[10] = '{8'd240, 1'b0, 8'd250, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sel", 64'(sel_count), 64'd0);
        check("rst_enable", 64'(sprite_enable), 64'd0);
        check("rst_req", 64'(bus.fetch_req), 64'd0);

        // Every entry carries the same y, so a visible vector selects entries 0..9 only.
        ack_mode = 0;
        for (int i = 0; i < 11; i++) begin
            set_oam(vecs[i].y);
            exp_q.delete();
            if (vecs[i].vis)
                for (int k = 0; k < 10; k++) push_sprite(6'(k));
            start_line(vecs[i].v, vecs[i].sz);
            wait_done($sformatf("vec%0d", i), 200);
            if (done_q.size() > 0)
                check($sformatf("vec%0d_done_at", i), 64'(done_q[0]), vecs[i].vis ? 64'd62 : 64'd42);
            check($sformatf("vec%0d_sel", i), 64'(sel_count), vecs[i].vis ? 64'd10 : 64'd0);
            check($sformatf("vec%0d_enable", i), 64'(sprite_enable), vecs[i].vis ? 64'h3FF : 64'h0);
            check_log($sformatf("vec%0d_log", i));
        end

        // Two visible entries, ack tied high: four back-to-back bytes.
        set_oam(8'd0);
        oam_y[3] = 8'd66;
        oam_y[7] = 8'd66;
        exp_q.delete();
        push_sprite(6'd3);
        push_sprite(6'd7);
        start_line(8'd50, 1'b0);
        wait_done("pair", 200);
        if (done_q.size() > 0) check("pair_done_at", 64'(done_q[0]), 64'd46);
        check("pair_sel", 64'(sel_count), 64'd2);
        check("pair_enable", 64'(sprite_enable), 64'h88);
        check_log("pair_log");

        // Same list with three wait cycles before every ack.
        ack_mode = 1;
        start_line(8'd50, 1'b0);
        wait_done("slow", 300);
        if (done_q.size() > 0) check("slow_done_at", 64'(done_q[0]), 64'd58);
        check_log("slow_log");

        // Restart in the middle of the second byte of the delayed-ack line.
        start_line(8'd50, 1'b0);
        while (cyc - t0 < 47) begin
            @(negedge clk);
            #2;
        end
        oam_y[3] = 8'd0;
        oam_y[7] = 8'd0;
        oam_y[20] = 8'd66;
        exp_q.delete();
        push_sprite(6'd20);
        start_line(8'd50, 1'b0);
        check("abort_req_drop", 64'(bus.fetch_req), 64'd0);
        check("abort_sel_clr", 64'(sel_count), 64'd0);
        check("abort_enable_clr", 64'(sprite_enable), 64'd0);
        check("abort_busy", 64'(busy), 64'd1);
        check("abort_scan_idx0", 64'(bus.scan_index), 64'd0);
        repeat (5) begin
            @(negedge clk);
            #2;
        end
        check("abort_scan_idx5", 64'(bus.scan_index), 64'd5);
        wait_done("abort", 300);
        if (done_q.size() > 0) check("abort_done_at", 64'(done_q[0]), 64'd50);
        repeat (5) @(negedge clk);
        #2;
        check("abort_done_count", 64'(done_q.size()), 64'd1);
        check("abort_sel", 64'(sel_count), 64'd1);
        check("abort_enable", 64'(sprite_enable), 64'h10_0000);
        check_log("abort_log");

        // Reset mid-scan, asserted together with a start: reset wins.
        ack_mode = 0;
        set_oam(8'd66);
        start_line(8'd50, 1'b0);
        while (cyc - t0 < 15) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        done_q.delete();
        #2;
        check("rscan_state", 64'(dbg_state), 64'd0);
        check("rscan_busy", 64'(busy), 64'd0);
        check("rscan_sel", 64'(sel_count), 64'd0);
        check("rscan_enable", 64'(sprite_enable), 64'd0);
        check("rscan_req", 64'(bus.fetch_req), 64'd0);
        check("rscan_scan_idx", 64'(bus.scan_index), 64'd0);
        check("rscan_done", 64'(done), 64'd0);
        repeat (70) @(negedge clk);
        #2;
        check("rscan_no_done", 64'(done_q.size()), 64'd0);

        check("ds_consistency", 64'(ds_err), 64'd0);
        check("req_stability", 64'(stab_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
